// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU/DIV/DIVU take WIDTH iteration cycles plus one sign-fix cycle.
//   MTHI/MTLO write HI/LO in a single cycle.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous reset, active-high
//   start  issue op (sampled on rising clk edge, ignored while busy)
//   op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   A      multiplicand / dividend / MTHI-MTLO source
//   B      multiplier / divisor
//   flush  abort the in-flight op; HI/LO keep their values
//   busy   iterative op in progress
//   done   one-cycle pulse coincident with the HI/LO write of a mul/div
//   HI     product upper half / remainder
//   LO     product lower half / quotient
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO write directly from here
// RUN   | one shift-add or restoring subtract-shift step per cycle
// FIX   | two's-complement sign correction, HI/LO write, done pulse
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic             load;
   logic             step;
   logic             wr_hilo;
   logic             wr_hi;
   logic             wr_lo;

   logic [CNT_W-1:0]   count;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               div0;
   // mcand holds the multiplicand for mul and the divisor for div.
   logic [WIDTH-1:0]   mcand;
   // acc is the 2*WIDTH product shift register for mul; for div its low
   // half starts as the dividend and fills with quotient bits.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   // operand magnitudes and signs for the load cycle
   logic             sgn_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign sgn_op = ~op[0];
   assign a_neg  = sgn_op & A[WIDTH-1];
   assign b_neg  = sgn_op & B[WIDTH-1];
   // 0x80..0 negates to itself, which read unsigned is exactly 2^(WIDTH-1)
   assign a_mag  = a_neg ? -A : A;
   assign b_mag  = b_neg ? -B : B;

   // multiply step: conditional add into the upper half, then shift right
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_mul_nxt;

   assign mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
   assign acc_mul_nxt = {mul_sum, acc[WIDTH-1:1]};

   // restoring divide step on a WIDTH+1 bit partial remainder
   logic [WIDTH:0] div_shift;
   logic           div_ge;
   logic [WIDTH:0] div_rem_nxt;

   assign div_shift   = {rem, acc[WIDTH-1]};
   assign div_ge      = (div_shift >= {1'b0, mcand});
   assign div_rem_nxt = div_ge ? (div_shift - {1'b0, mcand}) : div_shift;

   // sign correction applied in FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   hi_res;
   logic [WIDTH-1:0]   lo_res;

   assign prod_fix = neg_q ? -acc : acc;
   // divide by zero leaves an all-ones quotient; the remainder path then
   // holds |A| and its sign fix restores the raw A.
   assign quo_fix  = div0 ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
   assign rem_fix  = neg_r ? -rem : rem;
   assign hi_res   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
   assign lo_res   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      wr_hilo   = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               if (!op[2]) begin
                  load      = 1'b1;
                  state_nxt = RUN;
               end else if (op == 3'b100) begin
                  wr_hi = 1'b1;
               end else if (op == 3'b101) begin
                  wr_lo = 1'b1;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (count == CNT_LAST) begin
                  state_nxt = FIX;
               end
            end
         end
         FIX: begin
            state_nxt = IDLE;
            wr_hilo   = !flush;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         mcand  <= '0;
         acc    <= '0;
         rem    <= '0;
      end else if (load) begin
         count  <= '0;
         is_div <= op[1];
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         div0   <= op[1] & (B == '0);
         mcand  <= op[1] ? b_mag : a_mag;
         acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
         rem    <= '0;
      end else if (step) begin
         count <= count + CNT_W'(1);
         if (is_div) begin
            rem              <= div_rem_nxt[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
         end else begin
            acc <= acc_mul_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= wr_hilo;
         if (wr_hilo) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
         end else begin
            if (wr_hi) hi_q <= A;
            if (wr_lo) lo_q <= A;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
